// File: rtl/hpt_axis_param_pkg.sv
// Shared types and helpers for the parametrised HPT-axis controller.
package hpt_axis_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_TRIGGERED    = 3'd1,
    ST_HYPOTHALAMUS = 3'd2,
    ST_PITUITARY    = 3'd3,
    ST_THYROID      = 3'd4,
    ST_REESTABLISH  = 3'd5,
    ST_SUPPRESS     = 3'd6,
    ST_FAULT        = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    RESP_HEALTHY = 2'd0,
    RESP_LOW     = 2'd1,
    RESP_HIGH    = 2'd2,
    RESP_FAULT   = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_HYPO   = 2'd1,
    MODE_HYPER  = 2'd2,
    MODE_FAIL   = 2'd3
  } mode_e;

  // Response code shown for each controller state.
  function automatic resp_e state_response(input state_e s);
    case (s)
      ST_IDLE, ST_REESTABLISH: return RESP_HEALTHY;
      ST_SUPPRESS:             return RESP_HIGH;
      ST_FAULT:                return RESP_FAULT;
      default:                 return RESP_LOW;
    endcase
  endfunction

  // a + d clamped to [0, 2^w-1]; callers truncate the result to w bits.
  // Valid for w up to 31.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic signed [31:0] d,
                                          input int unsigned w);
    logic signed [33:0] sum;
    logic signed [33:0] top;
    sum = $signed({2'b00, a}) + $signed({{2{d[31]}}, d});
    top = (34'sd1 <<< w) - 34'sd1;
    if (sum < 34'sd0) return 32'd0;
    if (sum > top) return top[31:0];
    return sum[31:0];
  endfunction

endpackage

// File: rtl/hpt_level_reg.sv
// Saturating hormone level register: two signed deltas applied in order,
// each step clamped, with an optional direct load.
module hpt_level_reg
  import hpt_axis_param_pkg::*;
#(
  parameter int unsigned LEVEL_W   = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic [LEVEL_W-1:0]        load_val_i,
  input  logic signed [LEVEL_W+1:0] delta_a_i,
  input  logic signed [LEVEL_W+1:0] delta_b_i,
  output logic [LEVEL_W-1:0]        level_d_o,
  output logic [LEVEL_W-1:0]        level_q_o
);

  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_d;
  logic [LEVEL_W-1:0] step1;

  // Next level: clamp after the first delta, then again after the second.
  always_comb begin
    step1   = LEVEL_W'(sat_add(32'(level_q), 32'(delta_a_i), LEVEL_W));
    level_d = LEVEL_W'(sat_add(32'(step1), 32'(delta_b_i), LEVEL_W));
    if (load_i) level_d = load_val_i;
  end

  // Level storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= LEVEL_W'(RESET_VAL);
    else     level_q <= level_d;
  end

  assign level_d_o = level_d;
  assign level_q_o = level_q;

endmodule

// File: rtl/hpt_axis_param.sv
// HPT-axis controller: episode FSM driving three saturating hormone levels,
// with negative-feedback suppression, pathology modes and a THYROID timeout.
module hpt_axis_param
  import hpt_axis_param_pkg::*;
#(
  parameter int unsigned LEVEL_W   = 8,
  parameter int unsigned SET_POINT = 128,
  parameter int unsigned HYST      = 16,
  parameter int unsigned STEP      = 8,
  parameter int unsigned KICK      = 32,
  parameter int unsigned DWELL     = 4,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trigger_low,
  input  logic               trigger_high,
  input  logic [1:0]         mode,
  input  logic               clear,
  output logic [2:0]         currentstate,
  output logic [1:0]         response,
  output logic [LEVEL_W-1:0] trh,
  output logic [LEVEL_W-1:0] tsh,
  output logic [LEVEL_W-1:0] t34,
  output logic [9:0]         currentImage,
  output logic               fault
);

  localparam int unsigned DW    = LEVEL_W + 2;
  localparam int unsigned CNT_W = 16;
  localparam logic signed [DW-1:0] STEP_D   = DW'(STEP);
  localparam logic signed [DW-1:0] HALF_D   = DW'(STEP >> 1);
  localparam logic signed [DW-1:0] DOUBLE_D = DW'(STEP << 1);
  localparam logic signed [DW-1:0] KICK_D   = DW'(KICK);
  localparam logic [LEVEL_W-1:0] SP_L = LEVEL_W'(SET_POINT);
  localparam logic [LEVEL_W-1:0] HI_L = LEVEL_W'(SET_POINT + HYST);
  localparam logic [LEVEL_W-1:0] LO_L = LEVEL_W'(SET_POINT - HYST);

  state_e state_q, state_d;
  mode_e  mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;   // cycles spent in the current state
  resp_e  resp_q;
  logic [9:0] image_q;
  logic   fault_q;
  logic [7:0] state_onehot;

  logic signed [DW-1:0] trh_delta, tsh_delta, t34_delta, trig_delta;
  logic [LEVEL_W-1:0] trh_q, tsh_q, t34_q;
  logic [LEVEL_W-1:0] trh_d, tsh_d, t34_d;
  logic body_low, body_high;

  // External triggers; opposing pulses cancel.
  always_comb begin
    trig_delta = '0;
    if (trigger_low && !trigger_high)      trig_delta = -KICK_D;
    else if (trigger_high && !trigger_low) trig_delta = KICK_D;
  end

  // Per-state hormone drive; depends only on registered state and mode.
  always_comb begin
    trh_delta = '0;
    tsh_delta = '0;
    t34_delta = '0;
    case (state_q)
      ST_HYPOTHALAMUS: trh_delta = STEP_D;
      ST_PITUITARY:    tsh_delta = STEP_D;
      ST_THYROID: begin
        case (mode_q)
          MODE_NORMAL: t34_delta = STEP_D;
          MODE_HYPO:   t34_delta = HALF_D;
          MODE_HYPER:  t34_delta = DOUBLE_D;
          default:     t34_delta = '0;
        endcase
      end
      ST_REESTABLISH: begin
        trh_delta = -STEP_D;
        tsh_delta = -STEP_D;
      end
      ST_SUPPRESS: begin
        trh_delta = -STEP_D;
        tsh_delta = -STEP_D;
        t34_delta = (mode_q == MODE_HYPER) ? -HALF_D : -STEP_D;
      end
      default: ;
    endcase
  end

  hpt_level_reg #(.LEVEL_W(LEVEL_W), .RESET_VAL(0)) u_trh (
    .clk(clk), .rst(reset), .load_i(1'b0), .load_val_i('0),
    .delta_a_i(trh_delta), .delta_b_i('0),
    .level_d_o(trh_d), .level_q_o(trh_q)
  );

  hpt_level_reg #(.LEVEL_W(LEVEL_W), .RESET_VAL(0)) u_tsh (
    .clk(clk), .rst(reset), .load_i(1'b0), .load_val_i('0),
    .delta_a_i(tsh_delta), .delta_b_i('0),
    .level_d_o(tsh_d), .level_q_o(tsh_q)
  );

  hpt_level_reg #(.LEVEL_W(LEVEL_W), .RESET_VAL(SET_POINT)) u_t34 (
    .clk(clk), .rst(reset), .load_i(1'b0), .load_val_i('0),
    .delta_a_i(t34_delta), .delta_b_i(trig_delta),
    .level_d_o(t34_d), .level_q_o(t34_q)
  );

  assign body_low  = (t34_q < LO_L);
  assign body_high = (t34_q > HI_L);

  // Next-state logic; phase transitions test the updated (next) levels.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (body_low) begin
          state_d = ST_TRIGGERED;
          mode_d  = mode_e'(mode);
        end else if (body_high) begin
          state_d = ST_SUPPRESS;
          mode_d  = mode_e'(mode);
        end
      end
      ST_TRIGGERED:    if (cnt_q == CNT_W'(DWELL - 1)) state_d = ST_HYPOTHALAMUS;
      ST_HYPOTHALAMUS: if (trh_d >= SP_L) state_d = ST_PITUITARY;
      ST_PITUITARY:    if (tsh_d >= SP_L) state_d = ST_THYROID;
      ST_THYROID: begin
        if (t34_d >= SP_L)                       state_d = ST_REESTABLISH;
        else if (cnt_q == CNT_W'(TIMEOUT - 1))   state_d = ST_FAULT;
      end
      ST_REESTABLISH:  if (trh_d == '0 && tsh_d == '0) state_d = ST_IDLE;
      ST_SUPPRESS:     if (t34_d <= HI_L) state_d = ST_IDLE;
      ST_FAULT:        if (clear) state_d = ST_REESTABLISH;
      default:         state_d = ST_IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  assign state_onehot = 8'b1 << state_q;

  // State, latched mode, phase counter and the registered display decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_NORMAL;
      cnt_q   <= '0;
      resp_q  <= RESP_HEALTHY;
      image_q <= 10'b00_0000_0001;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      resp_q  <= state_response(state_q);
      image_q <= {mode_q, state_onehot};
      fault_q <= (state_q == ST_FAULT);
    end
  end

  assign currentstate = state_q;
  assign response     = resp_q;
  assign currentImage = image_q;
  assign fault        = fault_q;
  assign trh          = trh_q;
  assign tsh          = tsh_q;
  assign t34          = t34_q;

endmodule
